// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, per-key debounce FSM, registered level and press/release strobes.
// Optional auto-repeat of key_press while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int CNT_W           = 25
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level_n,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

`ifdef KEY_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   localparam bit AUTOREPEAT = 1'b0;
`endif

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {ST_UP, ST_DN_WAIT, ST_DOWN, ST_UP_WAIT} state_e;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      logic             sync1_q, sync1_d;
      logic             s_q, s_d;
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             rpt_q, rpt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic [CNT_W-1:0] rpt_limit;
      logic             rpt_hit;

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            sync1_q   <= 1'b1;
            s_q       <= 1'b1;
            state_q   <= ST_UP;
            cnt_q     <= '0;
            rpt_q     <= 1'b0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      // rpt_q clear means the next repeat is the first one, timed by REPEAT_DELAY
      always_comb begin
         rpt_limit = rpt_q ? RATE_LAST : DELAY_LAST;
         rpt_hit   = AUTOREPEAT && (cnt_q == rpt_limit);
      end

      always_comb begin
         sync1_d = key_n[g];
         s_d     = sync1_q;
         state_d = state_q;
         cnt_d   = cnt_q;
         rpt_d   = rpt_q;
         case (state_q)
            ST_UP: begin
               if (!s_q) begin
                  state_d = ST_DN_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_DN_WAIT: begin
               if (s_q) begin
                  state_d = ST_UP;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = ST_DOWN;
                  cnt_d   = '0;
                  rpt_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DOWN: begin
               if (s_q) begin
                  state_d = ST_UP_WAIT;
                  cnt_d   = CNT_W'(1);
               end else if (!AUTOREPEAT) begin
                  cnt_d = '0;
               end else if (rpt_hit) begin
                  cnt_d = '0;
                  rpt_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_UP_WAIT: begin
               if (!s_q) begin
                  state_d = ST_DOWN;
                  cnt_d   = '0;
                  rpt_d   = 1'b0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = ST_UP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_UP;
               cnt_d   = '0;
            end
         endcase
      end

      always_comb begin
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            ST_DN_WAIT: begin
               if (!s_q && cnt_q == DB_LAST) begin
                  level_d = 1'b0;
                  press_d = 1'b1;
               end
            end
            ST_DOWN: begin
               if (!s_q && rpt_hit) press_d = 1'b1;
            end
            ST_UP_WAIT: begin
               if (s_q && cnt_q == DB_LAST) begin
                  level_d   = 1'b1;
                  release_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      assign key_level_n[g] = level_q;
      assign key_press[g]   = press_q;
      assign key_release[g] = release_q;
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed vector table, hand-written reset/repeat sequences, random bouncing keys vs a reference model.
module tb_key_debounce;

   localparam int NK = 4;
   localparam int DB = 8;
   localparam int RD = 32;
   localparam int RR = 8;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NK-1:0] key_n = '1;
   logic [NK-1:0] key_level_n, key_press, key_release;

   int checks = 0;
   int errors = 0;

   key_debounce #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(25)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n),
      .key_level_n(key_level_n), .key_press(key_press), .key_release(key_release)
   );

   always #5 clk = ~clk;

   // Reference model: level flips after DB consecutive disagreeing samples of the synchronised key
   bit        m_sy1[NK], m_s[NK], m_lvl[NK], m_first[NK];
   int        m_run[NK], m_rep[NK];
   logic [NK-1:0] m_press, m_rel;

   function automatic void model_reset();
      for (int k = 0; k < NK; k++) begin
         m_sy1[k] = 1'b1; m_s[k] = 1'b1; m_lvl[k] = 1'b1;
         m_run[k] = 0; m_rep[k] = 0; m_first[k] = 1'b1;
      end
      m_press = '0; m_rel = '0;
   endfunction

   function automatic void model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
         if (m_s[k] != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
               m_lvl[k] = m_s[k];
               m_run[k] = 0; m_rep[k] = 0; m_first[k] = 1'b1;
               if (m_lvl[k] == 1'b0) m_press[k] = 1'b1;
               else                  m_rel[k]   = 1'b1;
            end
         end else if (m_run[k] != 0) begin
            m_run[k] = 0; m_rep[k] = 0; m_first[k] = 1'b1;
         end else if (m_lvl[k] == 1'b0 && AR) begin
            if (m_rep[k] == (m_first[k] ? RD : RR) - 1) begin
               m_press[k] = 1'b1; m_rep[k] = 0; m_first[k] = 1'b0;
            end else begin
               m_rep[k]++;
            end
         end
         m_s[k]   = m_sy1[k];
         m_sy1[k] = key_n[k];
      end
   endfunction

   function automatic logic [NK-1:0] model_level();
      logic [NK-1:0] v;
      for (int k = 0; k < NK; k++) v[k] = m_lvl[k];
      return v;
   endfunction

   task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [3*NK-1:0] act, exp;
      act = {key_level_n, key_press, key_release};
      exp = {model_level(), m_press, m_rel};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model: got lvl/prs/rel %h/%h/%h expected %h/%h/%h at %0t",
                  key_level_n, key_press, key_release, model_level(), m_press, m_rel, $time);
      end
   endtask

   // Called at a negedge; drives keys, advances one posedge, checks against the model, returns at next negedge
   task automatic tick(input logic [NK-1:0] k);
      key_n = k;
      @(posedge clk);
      model_step();
      #1;
      check_model();
      @(negedge clk);
   endtask

   task automatic reset_now_check(input string name);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({name, "_level"}, key_level_n, 4'hF);
      chk({name, "_press"}, key_press, 4'h0);
      chk({name, "_release"}, key_release, 4'h0);
   endtask

   typedef struct {
      string         name;
      logic [NK-1:0] key;
      int            cycles;
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
   } vec_t;

   vec_t vecs[19];

   initial begin
      bit            tgt[NK];
      int            bnc[NK];
      logic [NK-1:0] raw;
      logic          exp_p;

      vecs[0]  = '{"press0_wait",    4'hE, 9, 4'hF, 4'h0, 4'h0};
      vecs[1]  = '{"press0_fire",    4'hE, 1, 4'hE, 4'h1, 4'h0};
      vecs[2]  = '{"press0_once",    4'hE, 1, 4'hE, 4'h0, 4'h0};
      vecs[3]  = '{"bounce1_low",    4'hC, 5, 4'hE, 4'h0, 4'h0};
      vecs[4]  = '{"bounce1_high",   4'hE, 1, 4'hE, 4'h0, 4'h0};
      vecs[5]  = '{"bounce1_settle", 4'hC, 9, 4'hE, 4'h0, 4'h0};
      vecs[6]  = '{"bounce1_fire",   4'hC, 1, 4'hC, 4'h2, 4'h0};
      vecs[7]  = '{"bounce1_once",   4'hC, 1, 4'hC, 4'h0, 4'h0};
      vecs[8]  = '{"rel0_rise",      4'hD, 3, 4'hC, 4'h0, 4'h0};
      vecs[9]  = '{"rel0_glitch",    4'hC, 1, 4'hC, 4'h0, 4'h0};
      vecs[10] = '{"rel0_settle",    4'hD, 9, 4'hC, 4'h0, 4'h0};
      vecs[11] = '{"rel0_fire",      4'hD, 1, 4'hD, 4'h0, 4'h1};
      vecs[12] = '{"rel0_once",      4'hD, 1, 4'hD, 4'h0, 4'h0};
      vecs[13] = '{"rel1_wait",      4'hF, 9, 4'hD, 4'h0, 4'h0};
      vecs[14] = '{"rel1_fire",      4'hF, 1, 4'hF, 4'h0, 4'h2};
      vecs[15] = '{"rel1_once",      4'hF, 1, 4'hF, 4'h0, 4'h0};
      vecs[16] = '{"simul_wait",     4'h6, 9, 4'hF, 4'h0, 4'h0};
      vecs[17] = '{"simul_fire",     4'h6, 1, 4'h6, 4'h9, 4'h0};
      vecs[18] = '{"simul_once",     4'h6, 1, 4'h6, 4'h0, 4'h0};

      model_reset();
      #2;
      reset_now_check("por");
      tick(4'hF);
      tick(4'hF);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick(4'hF);

      foreach (vecs[v]) begin
         for (int c = 0; c < vecs[v].cycles; c++) tick(vecs[v].key);
         chk({vecs[v].name, "_level"}, key_level_n, vecs[v].lvl);
         chk({vecs[v].name, "_press"}, key_press, vecs[v].prs);
         chk({vecs[v].name, "_release"}, key_release, vecs[v].rel);
      end

      // Reset while key 2 is mid-debounce: the pending press must vanish
      for (int i = 0; i < 5; i++) tick(4'h2);
      #2;
      reset_now_check("mid_dn_wait");
      tick(4'hF);
      tick(4'hF);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(4'hF);
         chk("rst_no_strobe", key_press, 4'h0);
      end

      // Key 2 held through reset release, then held for the repeat window
      key_n = 4'hB;
      rst_n = 1'b0;
      tick(4'hB);
      tick(4'hB);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) tick(4'hB);
      chk("held_rst_wait_press", key_press, 4'h0);
      chk("held_rst_wait_level", key_level_n, 4'hF);
      tick(4'hB);
      chk("held_rst_fire_press", key_press, 4'h4);
      chk("held_rst_fire_level", key_level_n, 4'hB);
      for (int t = 1; t <= 70; t++) begin
         tick(4'hB);
         exp_p = AR && (t >= RD) && ((t - RD) % RR == 0);
         chk("repeat_press2", key_press, {1'b0, exp_p, 2'b00});
         chk("repeat_level", key_level_n, 4'hB);
      end
      for (int i = 0; i < 12; i++) tick(4'hF);
      chk("repeat_end_level", key_level_n, 4'hF);

      // Random bouncing keys against the model, with occasional asynchronous resets
      for (int k = 0; k < NK; k++) begin
         tgt[k] = 1'b1;
         bnc[k] = 0;
      end
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 39) == 0) begin
               tgt[k] = ~tgt[k];
               bnc[k] = $urandom_range(0, 12);
            end
            if (bnc[k] > 0) begin
               raw[k] = 1'($urandom_range(0, 1));
               bnc[k]--;
            end else begin
               raw[k] = tgt[k];
            end
         end
         if ($urandom_range(0, 799) == 0) begin
            #2;
            reset_now_check("rnd_rst");
            tick(raw);
            rst_n = 1'b1;
         end else begin
            tick(raw);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
